multicycle_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32I datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and performs the memory request/acknowledge handshakes. It gates the write strobes produced by the combinational control unit (RUWr, DMWr), so the register file and data memory are written in exactly one state per instruction. It sits between the instruction/data memories and the control unit plus datapath, and it also counts retired instructions and traps on illegal opcodes or a memory timeout.

---
 rtl/multicycle_sequencer_if.sv | 27 ++
 rtl/multicycle_sequencer.sv | 170 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer and the
// memories / control unit / datapath around it.
interface multicycle_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr;
    logic [31:0] IR;
    logic        RUWr;
    logic        DMWr;
    logic        RUWrEn;
    logic        DMWrEn;
    logic        dmem_req;
    logic        dmem_ack;
    logic        PCWr;

    // Sequencer side: issues requests and gated strobes.
    modport master (
        output imem_req, IR, RUWrEn, DMWrEn, dmem_req, PCWr,
        input  imem_ack, instr, RUWr, DMWr, dmem_ack
    );

    // Environment side: memories, control unit and datapath.
    modport slave (
        input  imem_req, IR, RUWrEn, DMWrEn, dmem_req, PCWr,
        output imem_ack, instr, RUWr, DMWr, dmem_ack
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXECUTE -> (MEM) -> WB.
// Gates the control unit's write requests so the register file and data
// memory are written in exactly one state per instruction, counts retired
// instructions and traps on illegal opcodes or a data-memory timeout.
module multicycle_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sequencer_if.master bus,
    output logic [2:0]            state,
    output logic [CNT_W-1:0]      retired,
    output logic                  trap,
    output logic [1:0]            trap_cause
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;

    logic [6:0] opcode;
    logic       op_legal;
    logic       op_mem;

    assign opcode = ir_q[6:0];
    assign op_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

    // Opcode legality check on the latched instruction.
    always_comb begin
        unique case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    // Next-state logic: state transitions, IR capture, retire count, traps.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                if (op_mem) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // An ack in the same cycle the limit is hit still completes.
                if (bus.dmem_ack) begin
                    state_d = S_WB;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                    if (tmo_d == TO_W'(MEM_TIMEOUT)) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'd2;
                    end
                end
            end
            S_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'd0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            tmo_q     <= tmo_d;
        end
    end

    // Moore decode of requests and gated strobes; all forced low during reset.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.DMWrEn   = 1'b0;
        bus.PCWr     = 1'b0;
        bus.RUWrEn   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: bus.imem_req = 1'b1;
                S_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.DMWrEn   = bus.DMWr;
                end
                S_WB: begin
                    bus.PCWr   = 1'b1;
                    bus.RUWrEn = bus.RUWr;
                end
                default: ;
            endcase
        end
    end

    assign bus.IR     = ir_q;
    assign state      = state_q;
    assign retired    = retired_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction pushes its
// expected outcome to a scoreboard queue; the entry is popped and compared
// when the DUT reaches WB->FETCH or TRAP.
module tb_multicycle_sequencer;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_sequencer_if bus();
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             trap;
    logic [1:0]       trap_cause;

    multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .state      (state),
        .retired    (retired),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    typedef struct {
        logic [31:0]      ir;
        logic             ruwren;
        logic [CNT_W-1:0] retired;
        logic [1:0]       cause;
    } exp_t;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] model_retired;
    logic [31:0]      last_ir;
    int               total = 0;
    int               bad   = 0;

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic bit is_mem(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011};
    endfunction

    // Called at a falling edge; holds reset for two rising edges.
    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.RUWr = 1'b1;
        bus.DMWr = 1'b1;
        bus.instr = 32'h0000_0033;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.RUWr = 1'b0;
        bus.DMWr = 1'b0;
        model_retired = '0;
        last_ir = '0;
        exp_q.delete();
    endtask

    // Runs one instruction from FETCH to FETCH (or TRAP). ack_wait: number of
    // MEM cycles without ack before the ack; negative means never.
    task automatic do_instr(input logic [31:0] w, input logic ruwr, input logic dmwr,
                            input int ack_wait, input string name);
        exp_t e, got;
        int   exp_tr[$];
        int   got_tr[$];
        int   mem_n, n_pcwr, n_ruwren, n_dmwren, n_dmreq, n_stray, exp_mem;
        bit   done, tr_ok;
        logic wb_ruwren;

        // Expected outcome from the opcode and memory behaviour.
        exp_tr.push_back(1);
        e.cause = 2'd0;
        if (!is_legal(w[6:0])) begin
            exp_tr.push_back(7);
            e.cause = 2'd1;
        end else begin
            exp_tr.push_back(2);
            if (is_mem(w[6:0]) && (ack_wait < 0 || ack_wait >= MEM_TIMEOUT)) begin
                repeat (MEM_TIMEOUT) exp_tr.push_back(3);
                exp_tr.push_back(7);
                e.cause = 2'd2;
            end else begin
                if (is_mem(w[6:0])) repeat (ack_wait + 1) exp_tr.push_back(3);
                exp_tr.push_back(4);
                exp_tr.push_back(0);
            end
        end
        exp_mem = 0;
        foreach (exp_tr[i]) if (exp_tr[i] == 3) exp_mem++;
        if (e.cause == 2'd0) model_retired = model_retired + 1'b1;
        e.ir      = w;
        e.ruwren  = (e.cause == 2'd0) ? ruwr : 1'b0;
        e.retired = model_retired;
        exp_q.push_back(e);

        #1;
        total++;
        if (state !== 3'd0 || bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL %s start: state=%0d imem_req=%b required state=0 imem_req=1", name, state, bus.imem_req);
        end
        bus.instr = w;
        bus.RUWr = ruwr;
        bus.DMWr = dmwr;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b0;
        mem_n = 0; n_pcwr = 0; n_ruwren = 0; n_dmwren = 0; n_dmreq = 0; n_stray = 0;
        wb_ruwren = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.instr = 32'hDEAD_BEEF;
            got_tr.push_back(int'(state));
            if (bus.PCWr === 1'b1) n_pcwr++;
            if (bus.RUWrEn === 1'b1) begin n_ruwren++; wb_ruwren = 1'b1; end
            if (bus.DMWrEn === 1'b1) n_dmwren++;
            if (bus.dmem_req === 1'b1) n_dmreq++;
            if (bus.imem_req === 1'b1 && state != 3'd0) n_stray++;
            if (bus.DMWrEn === 1'b1 && state != 3'd3) n_stray++;
            if ((bus.PCWr === 1'b1 || bus.RUWrEn === 1'b1) && state != 3'd4) n_stray++;
            if (state == 3'd3) begin
                mem_n++;
                bus.dmem_ack = (ack_wait >= 0 && mem_n == ack_wait + 1);
            end else begin
                bus.dmem_ack = 1'b1;  // stray ack outside MEM must be ignored
            end
            if (state == 3'd0 || state == 3'd7) done = 1'b1;
        end
        bus.dmem_ack = 1'b0;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: no return to FETCH/TRAP within 200 cycles, state=%0d", name, state);
        end

        tr_ok = (got_tr.size() == exp_tr.size());
        if (tr_ok) foreach (exp_tr[i]) if (got_tr[i] != exp_tr[i]) tr_ok = 1'b0;
        total++;
        if (!tr_ok) begin
            bad++;
            $display("FAIL %s trace: got %0d states ending %0d, required %0d states ending %0d",
                     name, got_tr.size(), (got_tr.size() > 0) ? got_tr[$] : -1,
                     exp_tr.size(), exp_tr[$]);
        end
        total++;
        if (n_pcwr != ((e.cause == 2'd0) ? 1 : 0) || n_ruwren != int'(e.ruwren) || n_stray != 0) begin
            bad++;
            $display("FAIL %s strobes: PCWr=%0d RUWrEn=%0d stray=%0d required PCWr=%0d RUWrEn=%0d stray=0",
                     name, n_pcwr, n_ruwren, n_stray, (e.cause == 2'd0) ? 1 : 0, e.ruwren);
        end
        total++;
        if (n_dmreq != exp_mem || n_dmwren != (dmwr ? exp_mem : 0)) begin
            bad++;
            $display("FAIL %s dmem: dmem_req=%0d DMWrEn=%0d required %0d and %0d",
                     name, n_dmreq, n_dmwren, exp_mem, dmwr ? exp_mem : 0);
        end

        // Scoreboard: output produced, pop and compare.
        got = exp_q.pop_front();
        total++;
        if (bus.IR !== got.ir || retired !== got.retired || wb_ruwren !== got.ruwren ||
            trap !== (got.cause != 2'd0) || trap_cause !== got.cause) begin
            bad++;
            $display("FAIL %s result: IR=%h retired=%0d ruwren=%b trap=%b cause=%0d required IR=%h retired=%0d ruwren=%b trap=%b cause=%0d",
                     name, bus.IR, retired, wb_ruwren, trap, trap_cause,
                     got.ir, got.retired, got.ruwren, got.cause != 2'd0, got.cause);
        end
        last_ir = w;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (state !== 3'd0 || bus.IR !== 32'h0 || retired !== '0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d IR=%h retired=%0d trap=%b cause=%0d required all 0",
                     state, bus.IR, retired, trap, trap_cause);
        end
        rst = 1'b1;
        bus.RUWr = 1'b1;
        bus.DMWr = 1'b1;
        #1;
        total++;
        if ({bus.imem_req, bus.dmem_req, bus.PCWr, bus.RUWrEn, bus.DMWrEn} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b required 00000",
                     {bus.imem_req, bus.dmem_req, bus.PCWr, bus.RUWrEn, bus.DMWrEn});
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_fetch_stall();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.instr = $urandom;
            @(negedge clk);
            total++;
            if (state !== 3'd0 || bus.IR !== last_ir || bus.imem_req !== 1'b1) begin
                bad++;
                $display("FAIL fetch_stall: state=%0d IR=%h imem_req=%b required state=0 IR=%h imem_req=1",
                         state, bus.IR, bus.imem_req, last_ir);
            end
        end
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_opcodes();
        logic [31:0] words [6] = '{32'h123450B7, 32'h00000097, 32'h0000006F,
                                   32'h00008067, 32'h00000063, 32'h00100093};
        logic        ruwrs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        foreach (words[i]) do_instr(words[i], ruwrs[i], 1'b0, 0, "opcode_mix");
    endtask

    task automatic test_illegal();
        bit ok = 1'b1;
        do_instr(32'hFFFF_FFFF, 1'b1, 1'b1, -1, "illegal");
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.RUWr = 1'b1;
        bus.DMWr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.instr = $urandom;
            @(negedge clk);
            if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd1 || bus.IR !== 32'hFFFF_FFFF ||
                retired !== model_retired ||
                {bus.imem_req, bus.dmem_req, bus.PCWr, bus.RUWrEn, bus.DMWrEn} !== 5'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL trap_hold: state=%0d trap=%b cause=%0d IR=%h retired=%0d required 7 1 1 ffffffff %0d",
                     state, trap, trap_cause, bus.IR, retired, model_retired);
        end
        do_reset();
        #1;
        total++;
        if (state !== 3'd0 || retired !== '0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
            bad++;
            $display("FAIL trap_exit: state=%0d retired=%0d trap=%b cause=%0d required 0 0 0 0",
                     state, retired, trap, trap_cause);
        end
    endtask

    task automatic test_reset_in_mem();
        int guard = 0;
        bus.instr = 32'h0010_2023;
        bus.DMWr = 1'b1;
        bus.RUWr = 1'b1;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b0;
        do begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            guard++;
        end while (state != 3'd3 && guard < 20);
        @(negedge clk);
        total++;
        if (state !== 3'd3 || bus.DMWrEn !== 1'b1 || bus.dmem_req !== 1'b1) begin
            bad++;
            $display("FAIL mem_before_rst: state=%0d DMWrEn=%b dmem_req=%b required 3 1 1",
                     state, bus.DMWrEn, bus.dmem_req);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.DMWrEn !== 1'b0 || bus.dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_gate: DMWrEn=%b dmem_req=%b required 0 0", bus.DMWrEn, bus.dmem_req);
        end
        @(negedge clk);
        total++;
        if (state !== 3'd0 || bus.PCWr !== 1'b0 || bus.RUWrEn !== 1'b0 || retired !== '0 || bus.IR !== 32'h0) begin
            bad++;
            $display("FAIL rst_in_mem: state=%0d PCWr=%b RUWrEn=%b retired=%0d IR=%h required 0 0 0 0 0",
                     state, bus.PCWr, bus.RUWrEn, retired, bus.IR);
        end
        rst = 1'b0;
        bus.DMWr = 1'b0;
        bus.RUWr = 1'b0;
        model_retired = '0;
        last_ir = '0;
        exp_q.delete();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++)
            do_instr(32'h0000_0033 | (32'(i + 1) << 7), 1'b1, 1'b0, 0, "wrap");
        total++;
        if (retired !== '0) begin
            bad++;
            $display("FAIL wrap_final: retired=%0d required 0", retired);
        end
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.instr = '0;
        bus.RUWr = 1'b0;
        bus.DMWr = 1'b0;
        model_retired = '0;
        last_ir = '0;
        @(negedge clk);
        test_reset();
        do_instr(32'h0000_0033, 1'b1, 1'b0, 0, "rtype_add");
        do_instr(32'h0000_2083, 1'b1, 1'b0, 3, "load_wait3");
        do_instr(32'h0010_2023, 1'b0, 1'b1, 0, "store");
        test_fetch_stall();
        do_instr(32'h0000_0033, 1'b1, 1'b0, 0, "back_to_back");
        test_opcodes();
        test_illegal();
        do_instr(32'h0000_2083, 1'b1, 1'b0, -1, "dmem_timeout");
        do_reset();
        do_instr(32'h0000_2083, 1'b1, 1'b0, MEM_TIMEOUT - 1, "ack_at_limit");
        test_reset_in_mem();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
